// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and types for the data memory controller
// Contents: access-size codes, controller state enum, wait-counter width.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - combinational byte-lane steering for loads and stores
// Ports:
//   size       in  access size (byte/half/word, 3 behaves as word)
//   addr_lo    in  byte offset within the word
//   wdata      in  right-aligned store data
//   sign_ld    in  sign-extend loads when 1
//   ram_word   in  raw word read from the RAM
//   wstrb      out per-lane write enables (all zero when misaligned)
//   wdata_rep  out store data replicated onto every candidate lane
//   ld_data    out extracted and extended load data (zero when misaligned)
//   misalign   out half on odd address or word on non-zero offset
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        sign_ld,
  input  logic [31:0] ram_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = ram_word[7:0];
    lane_h    = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    ld_data   = '0;
    misalign  = 1'b0;

    case (addr_lo)
      2'd0:    lane_b = ram_word[7:0];
      2'd1:    lane_b = ram_word[15:8];
      2'd2:    lane_b = ram_word[23:16];
      default: lane_b = ram_word[31:24];
    endcase

    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = {{24{sign_ld & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = {{16{sign_ld & lane_h[15]}}, lane_h};
      end
      default: begin
        misalign  = |addr_lo;
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        ld_data   = ram_word;
      end
    endcase

    // A misaligned access must neither write RAM nor return data.
    if (misalign) begin
      wstrb   = 4'b0000;
      ld_data = '0;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle word RAM with req/ack handshake and wait states
// Optional feature macro: DATA_MEM_PERF_EN (adds rd_count / wr_count outputs).
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req         access request, held with stable fields until ack
//   we          1 = store, 0 = load
//   addr        byte address (wraps modulo 4*DEPTH)
//   wdata       right-aligned store data
//   size        0 byte, 1 half, 2/3 word
//   sign_ld     sign-extend loads when 1
//   rdata       load result, valid with ack and held until the next ack
//   ack         one-cycle completion pulse
//   err         misaligned-access flag, only with ack
//   stall       req & ~ack
//   rd_count    (DATA_MEM_PERF_EN) successful loads
//   wr_count    (DATA_MEM_PERF_EN) successful stores
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic              sign_ld,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              stall
`ifdef DATA_MEM_PERF_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WS_INIT = WAIT_W'(WAIT_STATES);

  ctrl_state_t       state, next_state;
  logic [WAIT_W-1:0] wait_cnt;

  logic              lat_we;
  logic [AW+1:0]     lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_size;
  logic              lat_sign;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] ld_data;
  logic              misalign;

  // Address bits above the RAM span are deliberately ignored (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign ram_word = mem[lat_addr[AW+1:2]];

  byte_lane_align u_align (
    .size      (lat_size),
    .addr_lo   (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .sign_ld   (lat_sign),
    .ram_word  (ram_word),
    .wstrb     (wstrb),
    .wdata_rep (wdata_rep),
    .ld_data   (ld_data),
    .misalign  (misalign)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt == WAIT_W'(1)) next_state = ACCESS;
      ACCESS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: ack is the ACCESS cycle itself, so latency is WAIT_STATES+1
  // cycles after the IDLE cycle in which req was sampled.
  always_comb begin
    ack   = (state == ACCESS);
    err   = ack & misalign;
    rdata = ack ? ld_data : rdata_q;
    stall = req & ~ack;
  end

  // Request capture and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_WORD;
      lat_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wait_cnt  <= WS_INIT;
            lat_we    <= we;
            lat_addr  <= addr[AW+1:0];
            lat_wdata <= wdata;
            lat_size  <= size;
            lat_sign  <= sign_ld;
          end
        end
        WAIT:    wait_cnt <= wait_cnt - WAIT_W'(1);
        default: wait_cnt <= wait_cnt;
      endcase
    end
  end

  // Held load result between acks
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (ack) begin
      rdata_q <= ld_data;
    end
  end

  // RAM write; reset in the ACCESS cycle drops the pending store.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && lat_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[lat_addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

`ifdef DATA_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (ack && !misalign) begin
      if (lat_we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, multi-cycle successor to the single-cycle data memory: word-organised RAM behind a request/acknowledge handshake with programmable wait states.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Sits between the CPU data port and storage in the next-generation top level; the CPU stalls on `stall` until `ack`.

Parameters:
- DATA_W, 32, data word width in bits; fixed at 32 for the lane logic.
- DEPTH, 256, number of words; must be a power of 2.
- WAIT_STATES, 2, extra cycles per access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; CPU holds it, with stable fields, until `ack`.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- sign_ld  in  1  load sign-extends when 1, zero-extends when 0.
- rdata  out  32  load result; valid in the `ack` cycle and held until the next `ack`.
- ack  out  1  one-cycle completion pulse.
- err  out  1  misaligned access flag; valid with `ack`.
- stall  out  1  combinational: `req & ~ack`.

Behaviour:
- Reset values: state IDLE, `ack` 0, `err` 0, `rdata` 0, wait counter 0. RAM contents are not cleared.
- State machine has three states: IDLE, WAIT, ACCESS.
- IDLE: on `req`, latch `addr`, `wdata`, `we`, `size`, `sign_ld` and load counter = WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else to ACCESS.
- WAIT: decrement the counter each cycle. When it reaches 1, go to ACCESS the next cycle.
- ACCESS: perform the access and register `rdata`, `ack` = 1 and `err`, then return to IDLE.
- Latency: `ack` is high exactly WAIT_STATES+1 cycles after the cycle `req` is sampled in IDLE.
- A `req` still high in the IDLE cycle after `ack` is a new request. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Word index is `addr[log2(DEPTH)+1:2]`; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Byte store writes only lane `addr[1:0]`.
- Half store writes lanes {1,0} or {3,2} per `addr[1]`.
- Word store writes all 4 lanes.
- Little-endian: lane 0 = bits [7:0].
- Loads extract the addressed lane(s), then sign-extend (bit 7 or bit 15) or zero-extend per `sign_ld`.
- Misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No RAM write occurs.
  - `rdata` is set to 0.
  - `err` = 1 with `ack`, after the normal latency.
- `err` is 0 in all other cycles.
- `req` deasserted mid-access (protocol violation): the access still completes and `ack` is still issued.
- Reset mid-access: returns to IDLE next edge, no `ack`, a pending store is dropped, and RAM is untouched.
- `we`, `addr`, `wdata` changing while not in IDLE have no effect, because they are latched.

Optional Feature:
- Macro: DATA_MEM_PERF_EN.
- With the macro defined:
  - Adds outputs `rd_count[31:0]` and `wr_count[31:0]`.
  - Each counter increments on `ack` of a successful, non-`err` load or store respectively.
  - Both reset to 0 and wrap at 2^32.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package `mem_pkg`:
  - Size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - Controller state enum {IDLE, WAIT, ACCESS}.
  - WAIT_W=4 counter-width constant.
- One combinational sub-module, `byte_lane_align`:
  - From `size`, `addr[1:0]`, `wdata`, `sign_ld` and the raw RAM word, it produces the 4-bit write strobe, the lane-replicated store data, the extended load data and the misalign flag.
- The controller FSM and RAM array stay in `data_mem_ctrl`.

Test Plan:
- WAIT_STATES=2: word store `addr` 0x10, `wdata` 0xDEADBEEF, then word load `addr` 0x10 → `ack` 3 cycles after each `req`; `rdata`=0xDEADBEEF; `stall` high for 3 cycles per access.
- Preload 0xDEADBEEF at 0x10; byte load `addr` 0x13 with `sign_ld`=1 → 0xFFFFFFDE; with `sign_ld`=0 → 0x000000DE; half load 0x12 with `sign_ld`=1 → 0xFFFFDEAD.
- Byte store 0xA5 to 0x11 over 0x11223344 → word at 0x10 reads 0x1122A544; half store 0xBEEF to 0x12 → 0xBEEFA544.
- Word store at 0x06 → `err`=1 with `ack`, `rdata`=0, RAM unchanged; half load at 0x05 → `err`=1.
- DEPTH=256: store 0x55 at byte address 0x400 → reads back at 0x000 (wrap).
- Reset asserted in WAIT during a store to 0x20 → no `ack`; 0x20 keeps its old value; next request completes normally. WAIT_STATES=0 → `ack` 1 cycle after `req`.
